sdp_ram: RTL and testbench
==========================

// Module: sdp_ram
// PURPOSE
//  Simple dual-port synchronous RAM: one write port and one read port, both on clk.
//  Default organisation 16 words x 8 bits.
//  General-purpose scratch storage for datapath blocks needing concurrent write and read.
//  Read data is registered: one cycle of latency, with write-to-read bypass.
// PARAMETERS
//  DATA_W   8    width of each word in bits
//  ADDR_W   4    address width in bits
//  DEPTH    16   number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
// PORTS
//  clk     in   1       clock; all state updates on rising edge
//  rst_n   in   1       reset, asynchronous assert, active-low
//  wrEn    in   1       write enable, active-high
//  wrAddr  in   ADDR_W  write address
//  wrData  in   DATA_W  write data
//  rdAddr  in   ADDR_W  read address; read is always enabled
//  rdData  out  DATA_W  registered read data
// BEHAVIOUR
//  Reset (already decided): one clock; reset is asynchronous and active-low.
//  - rst_n=0 immediately forces rdData=0 and clears every memory word to 0.
//  - The block holds this state while rst_n=0 and ignores wrEn.
//  - Release is synchronised by the user.
//  - The first write is honoured on the first rising edge with rst_n=1.
//  Write: at posedge clk with wrEn=1 and wrAddr<DEPTH, mem[wrAddr] <= wrData.
//  - wrEn=0, or X/Z on wrEn: no write.
//  - wrAddr >= DEPTH: write silently dropped; no aliasing or wrap.
//  Read: at every posedge clk, rdData <= mem[rdAddr].
//  - Latency is 1 cycle from rdAddr sampled to rdData valid.
//  - rdData holds its value between edges.
//  - rdAddr >= DEPTH returns 0.
//  Read-during-write, same address:
//  - At an edge with wrEn=1 and rdAddr==wrAddr<DEPTH, rdData <= wrData.
//  - The bypass returns the new data, never the stale word.
//  Read-during-write, different addresses: fully independent; both complete in one cycle.
//  Memory contents persist indefinitely without reset; there is no refresh or clear port.
//  The read path carries no combinational path from inputs to rdData.
// TESTING
//  1 Reset: assert rst_n=0 mid-run after writes.
//    -> rdData=0 immediately, with no clock edge needed.
//    -> Reads of addr 0..15 all return 0 after release.
//  2 Fill/readback: write 25..37 to addr 0..12 (wrEn=1, one per cycle), then wrEn=0 and read 0..12.
//    -> rdData = 25..37, each one cycle after its rdAddr.
//    -> Addr 13..15 read 0.
//  3 Write disabled: wrEn=0, wrAddr=3, wrData=8'hFF.
//    -> Reading addr 3 still returns 28.
//  4 Collision: wrEn=1, wrAddr=rdAddr=5, wrData=8'hA5 on a single edge.
//    -> rdData=8'hA5 after that edge.
//    -> A later read of addr 5 returns 8'hA5.
//  5 Independent ports: same edge writes addr 7=8'h11 and reads addr 2.
//    -> rdData=27.
//    -> Next read of addr 7 returns 8'h11.
//  6 Boundary/param: DEPTH=12 build, write addr 14=8'h55.
//    -> Read addr 14 returns 0.
//    -> Addr 0..11 unchanged.
//    -> Also check addr 15 read/write at default DEPTH=16.

Source files
------------

// File: rtl/sdp_ram_if.sv
// Write/read port bundle for sdp_ram: one write port, one always-enabled read port.
// The master drives addresses, data and enable; the slave returns registered read data.
interface sdp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM on a single clock with registered read and same-address write bypass.
// Asynchronous reset clears both the read register and every stored word.
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic      clk,
    input logic      rst_n,
    sdp_ram_if.slave bus
);
    // Addresses are zero-extended by one bit so DEPTH == 2**ADDR_W compares cleanly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_hit;
    logic              rd_in_range;
    logic              bypass;
    logic [DATA_W-1:0] rd_next;

    always_comb begin
        wr_hit      = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
        rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;
        bypass      = wr_hit && (bus.wr_addr == bus.rd_addr);
        rd_next     = '0;
        if (bypass) begin
            rd_next = bus.wr_data;
        end else if (rd_in_range) begin
            rd_next = mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_next;
        end
    end
endmodule

// File: tb/tb_sdp_ram.sv
// Directed bench for sdp_ram: default 16-word build plus a 12-word build for range checks.
module tb_sdp_ram;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    sdp_ram_if #(.DATA_W(8), .ADDR_W(4)) bus16 ();
    sdp_ram_if #(.DATA_W(8), .ADDR_W(4)) bus12 ();

    sdp_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    sdp_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic en, input logic [3:0] wa, input logic [7:0] wd,
                           input logic [3:0] ra);
        bus16.wr_en   = en;
        bus16.wr_addr = wa;
        bus16.wr_data = wd;
        bus16.rd_addr = ra;
    endtask

    task automatic drive12(input logic en, input logic [3:0] wa, input logic [7:0] wd,
                           input logic [3:0] ra);
        bus12.wr_en   = en;
        bus12.wr_addr = wa;
        bus12.wr_data = wd;
        bus12.rd_addr = ra;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive16(1'b0, 4'd0, 8'h00, 4'd0);
        drive12(1'b0, 4'd0, 8'h00, 4'd0);
        #3;
        chk("reset_rd_data", bus16.rd_data, 8'h00);
        #20;
        rst_n = 1'b1;
        #3;

        // Fill addr 0..12 with 25..37, one write per edge
        for (int i = 0; i < 13; i++) begin
            drive16(1'b1, 4'(i), 8'(25 + i), 4'd15);
            tick();
        end
        drive16(1'b0, 4'd0, 8'h00, 4'd0);
        for (int i = 0; i < 16; i++) begin
            bus16.rd_addr = 4'(i);
            tick();
            chk($sformatf("fill_rd_%0d", i), bus16.rd_data, (i < 13) ? 8'(25 + i) : 8'h00);
        end

        // Disabled write must not touch addr 3
        drive16(1'b0, 4'd3, 8'hFF, 4'd3);
        tick();
        chk("wr_disabled_same_edge", bus16.rd_data, 8'd28);
        drive16(1'b0, 4'd0, 8'h00, 4'd3);
        tick();
        chk("wr_disabled_readback", bus16.rd_data, 8'd28);

        // Same-address collision returns new data
        drive16(1'b1, 4'd5, 8'hA5, 4'd5);
        tick();
        chk("collision_bypass", bus16.rd_data, 8'hA5);
        drive16(1'b0, 4'd0, 8'h00, 4'd5);
        tick();
        chk("collision_readback", bus16.rd_data, 8'hA5);

        // rd_data holds between edges despite rd_addr change
        bus16.rd_addr = 4'd0;
        #3;
        chk("rd_hold_no_comb_path", bus16.rd_data, 8'hA5);
        tick();
        chk("rd_addr0_after_hold", bus16.rd_data, 8'd25);

        // Independent ports on one edge
        drive16(1'b1, 4'd7, 8'h11, 4'd2);
        tick();
        chk("indep_read_addr2", bus16.rd_data, 8'd27);
        drive16(1'b0, 4'd0, 8'h00, 4'd7);
        tick();
        chk("indep_readback_addr7", bus16.rd_data, 8'h11);

        // Top address at full depth
        drive16(1'b1, 4'd15, 8'h5A, 4'd0);
        tick();
        drive16(1'b0, 4'd0, 8'h00, 4'd15);
        tick();
        chk("addr15_readback", bus16.rd_data, 8'h5A);

        // Unknown enable performs no write
        drive16(1'bx, 4'd4, 8'h00, 4'd4);
        tick();
        drive16(1'b0, 4'd0, 8'h00, 4'd4);
        tick();
        chk("x_wr_en_no_write", bus16.rd_data, 8'd29);

        // Mid-run reset: rd_data clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_async", bus16.rd_data, 8'h00);
        drive16(1'b1, 4'd0, 8'h77, 4'd0);
        tick();
        chk("reset_ignores_write", bus16.rd_data, 8'h00);
        drive16(1'b0, 4'd0, 8'h00, 4'd0);
        #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            bus16.rd_addr = 4'(i);
            tick();
            chk($sformatf("post_reset_rd_%0d", i), bus16.rd_data, 8'h00);
        end

        // First write right after release is honoured
        drive16(1'b1, 4'd1, 8'h3C, 4'd0);
        tick();
        drive16(1'b0, 4'd0, 8'h00, 4'd1);
        tick();
        chk("first_write_after_release", bus16.rd_data, 8'h3C);

        // 12-word build: out-of-range write dropped, no aliasing
        for (int i = 0; i < 12; i++) begin
            drive12(1'b1, 4'(i), 8'(8'h40 + i), 4'd0);
            tick();
        end
        drive12(1'b1, 4'd14, 8'h55, 4'd14);
        tick();
        chk("d12_collision_out_of_range", bus12.rd_data, 8'h00);
        drive12(1'b0, 4'd0, 8'h00, 4'd14);
        tick();
        chk("d12_rd_addr14", bus12.rd_data, 8'h00);
        for (int i = 0; i < 12; i++) begin
            bus12.rd_addr = 4'(i);
            tick();
            chk($sformatf("d12_rd_%0d", i), bus12.rd_data, 8'(8'h40 + i));
        end
        bus12.rd_addr = 4'd12;
        tick();
        chk("d12_rd_addr12", bus12.rd_data, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
